chain_decoder: RTL

Freeman chain-code decoder for the border-imaging pipeline. It consumes the start point and 3-bit direction codes produced by the border encoder and redraws the closed contour into a 64x64 one-bit frame memory through a write port. It also counts the perimeter and checks that the contour stays inside the frame and closes on its start pixel. It is used for round-trip verification of the encoder and for rendering stored contours.

---
 rtl/chain_decoder_if.sv | 36 +++
 rtl/chain_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/chain_decoder_if.sv
// Chain decoder bus: start/origin, direction-code stream, frame write port
// and status outputs. "master" is the code source, "slave" is the decoder.
//
// Code handshake: a code transfers on a rising edge where code_valid and
// code_ready are both high; code_ready is only ever high while the decoder
// is in DECODE, and a code offered at any other time is simply not taken.
interface chain_decoder_if;
  logic        start;
  logic [5:0]  start_x;
  logic [5:0]  start_y;
  logic        code_valid;
  logic [2:0]  code;
  logic        code_last;
  logic        code_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic        wr_data;
  logic [5:0]  cur_x;
  logic [5:0]  cur_y;
  logic [7:0]  Permiter;
  logic        Done;
  logic        Error;
  logic [2:0]  dbg_state;

  modport master (
    output start, start_x, start_y, code_valid, code, code_last,
    input  code_ready, wr_en, wr_addr, wr_data, cur_x, cur_y, Permiter,
           Done, Error, dbg_state
  );

  modport slave (
    input  start, start_x, start_y, code_valid, code, code_last,
    output code_ready, wr_en, wr_addr, wr_data, cur_x, cur_y, Permiter,
           Done, Error, dbg_state
  );
endinterface

// File: rtl/chain_decoder.sv
// Freeman chain-code decoder: redraws a closed contour into a 64x64 1-bit
// frame through a write port, counts the perimeter and flags contours that
// leave the frame, overflow the counter or fail to close on the start pixel.
// Optional feature macro: CHAIN_DECODER_CLEAR_EN -- when defined, every
// decode begins with a 4096-cycle pass writing zeros to the whole frame;
// when undefined the frame is overlaid without clearing.
// All outputs come straight from registers; dbg_state exposes the FSM state.
module chain_decoder (
  input  logic           Clk,
  input  logic           reset,
  chain_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
`ifdef CHAIN_DECODER_CLEAR_EN
    S_CLEAR  = 3'd1,
`endif
    S_PLOT   = 3'd2,
    S_DECODE = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cur_x_q, cur_x_d;
  logic [5:0]  cur_y_q, cur_y_d;
  logic [5:0]  org_x_q, org_x_d;
  logic [5:0]  org_y_q, org_y_d;
  logic [7:0]  perim_q, perim_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        ready_q, ready_d;
  logic        wr_en_q, wr_en_d;
  logic        wr_data_q, wr_data_d;
  logic [11:0] wr_addr_q, wr_addr_d;

  // Signed deltas in two's complement: 01 = +1, 11 = -1, 00 = 0.
  logic [1:0]  dx, dy;
  // One extra bit so stepping below 0 or above 63 shows up in bit 6.
  logic [6:0]  nx, ny;
  logic        hs, oob, ovf, closes;

  // Direction code to (dx, dy); y grows downwards, so "north" is -y.
  always_comb begin
    dx = 2'b00;
    dy = 2'b00;
    case (bus.code)
      3'd0: dx = 2'b01;
      3'd1: begin dx = 2'b01; dy = 2'b11; end
      3'd2: dy = 2'b11;
      3'd3: begin dx = 2'b11; dy = 2'b11; end
      3'd4: dx = 2'b11;
      3'd5: begin dx = 2'b11; dy = 2'b01; end
      3'd6: dy = 2'b01;
      3'd7: begin dx = 2'b01; dy = 2'b01; end
    endcase
  end

  assign nx     = {1'b0, cur_x_q} + {{5{dx[1]}}, dx};
  assign ny     = {1'b0, cur_y_q} + {{5{dy[1]}}, dy};
  assign hs     = bus.code_valid & ready_q;
  assign oob    = nx[6] | ny[6];
  assign ovf    = (perim_q == 8'hFF);
  assign closes = ({ny[5:0], nx[5:0]} == {org_y_q, org_x_q});

  // Next-state and registered-output logic; writes are one-cycle pulses.
  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    org_x_d   = org_x_q;
    org_y_d   = org_y_q;
    perim_d   = perim_q;
    done_d    = done_q;
    error_d   = error_q;
    ready_d   = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          cur_x_d = bus.start_x;
          cur_y_d = bus.start_y;
          org_x_d = bus.start_x;
          org_y_d = bus.start_y;
          perim_d = 8'd0;
          done_d  = 1'b0;
          error_d = 1'b0;
          wr_en_d = 1'b1;
`ifdef CHAIN_DECODER_CLEAR_EN
          state_d   = S_CLEAR;
          wr_data_d = 1'b0;
          wr_addr_d = 12'd0;
`else
          state_d   = S_PLOT;
          wr_data_d = 1'b1;
          wr_addr_d = {bus.start_y, bus.start_x};
`endif
        end
      end

`ifdef CHAIN_DECODER_CLEAR_EN
      S_CLEAR: begin
        wr_en_d = 1'b1;
        if (wr_addr_q == 12'hFFF) begin
          state_d   = S_PLOT;
          wr_data_d = 1'b1;
          wr_addr_d = {org_y_q, org_x_q};
        end else begin
          wr_data_d = 1'b0;
          wr_addr_d = wr_addr_q + 12'd1;
        end
      end
`endif

      S_PLOT: begin
        state_d = S_DECODE;
        ready_d = 1'b1;
      end

      S_DECODE: begin
        ready_d = 1'b1;
        if (hs) begin
          if (oob || ovf) begin
            // Rejected step: pen and counter stay put, nothing is drawn.
            state_d = S_ERR;
            error_d = 1'b1;
            ready_d = 1'b0;
          end else begin
            cur_x_d   = nx[5:0];
            cur_y_d   = ny[5:0];
            perim_d   = perim_q + 8'd1;
            wr_en_d   = 1'b1;
            wr_data_d = 1'b1;
            wr_addr_d = {ny[5:0], nx[5:0]};
            if (bus.code_last) begin
              ready_d = 1'b0;
              if (closes) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = S_ERR;
                error_d = 1'b1;
              end
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_x_q   <= 6'd0;
      cur_y_q   <= 6'd0;
      org_x_q   <= 6'd0;
      org_y_q   <= 6'd0;
      perim_q   <= 8'd0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 1'b0;
      wr_addr_q <= 12'd0;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      org_x_q   <= org_x_d;
      org_y_q   <= org_y_d;
      perim_q   <= perim_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign bus.code_ready = ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cur_x      = cur_x_q;
  assign bus.cur_y      = cur_y_q;
  assign bus.Permiter   = perim_q;
  assign bus.Done       = done_q;
  assign bus.Error      = error_q;
  assign bus.dbg_state  = state_q;

endmodule
